// File: rtl/conv3x3_stream_pipe.sv
// -----------------------------------------------------------------------------
// conv3x3_stream_pipe
//
// Streaming 3x3 convolution engine. Pixels arrive in raster order (with
// optional bubbles) and flow through two line buffers into a 3x3 shift
// window. Each completed window is turned into one output in a 3-stage
// pipeline: products (T+1), row sums (T+2), final sum / Out_OFM (T+3),
// where T is the cycle in which the window's last pixel is accepted.
//
// Optional feature macro: CONV_RELU_EN
//   defined   : Out_OFM = max(sum, 0), applied in the T+3 stage
//   undefined : Out_OFM = raw signed sum
//
// Parameters:
//   DATA_W  pixel / weight width (signed)
//   IMG_W   frame width  (>= 3)
//   IMG_H   frame height (>= 3)
//   STRIDE  window stride, 1 or 2 only
//   OUT_W   output width, fixed to 2*DATA_W+4
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   in_valid      pixel beat valid
//   in_ready      block accepts a pixel this cycle
//   weight_valid  weight beat valid, sampled only with an accepted pixel
//   In_IFM        pixel, signed
//   In_Weight     weight, signed
//   out_valid     Out_OFM valid, one-cycle pulse per output
//   Out_OFM       convolution result, signed, holds between pulses
//   frame_done    one-cycle pulse after the last output of a frame
// -----------------------------------------------------------------------------
module conv3x3_stream_pipe #(
    parameter int   DATA_W = 16,
    parameter int   IMG_W  = 7,
    parameter int   IMG_H  = 7,
    parameter int   STRIDE = 1,
    localparam int  OUT_W  = 2*DATA_W + 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              weight_valid,
    input  logic [DATA_W-1:0] In_IFM,
    input  logic [DATA_W-1:0] In_Weight,
    output logic              out_valid,
    output logic [OUT_W-1:0]  Out_OFM,
    output logic              frame_done
);

    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int PROD_W = 2*DATA_W;
    localparam int RSUM_W = 2*DATA_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e                    state_q, state_d;
    logic [1:0]                drain_q, drain_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [3:0]                wcnt_q, wcnt_d;
    logic signed [DATA_W-1:0]  wbuf_q [9];
    logic signed [DATA_W-1:0]  wbuf_d [9];
    logic signed [DATA_W-1:0]  win_q  [3][3];
    logic signed [DATA_W-1:0]  win_d  [3][3];
    logic signed [DATA_W-1:0]  lb0_q  [IMG_W];   // previous row
    logic signed [DATA_W-1:0]  lb1_q  [IMG_W];   // two rows back
    logic signed [PROD_W-1:0]  prod_q [9];
    logic signed [RSUM_W-1:0]  rsum_q [3];
    logic signed [OUT_W-1:0]   sum_d, ofm_d, ofm_q;
    logic                      v1_q, v2_q, out_valid_q, frame_done_q;

    logic accept, last_pix, stride_ok, fire, frame_end;

    assign in_ready  = !rst && (state_q != S_DRAIN);
    assign accept    = in_valid && in_ready;
    assign last_pix  = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
    // With STRIDE 2 a window starts on every even row/col offset from 2,
    // i.e. on even row and column indices.
    assign stride_ok = (STRIDE == 1) || (!row_q[0] && !col_q[0]);
    assign fire      = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2)) && stride_ok;
    assign frame_end = (state_q == S_DRAIN) && (drain_q == 2'd2);

    // ---------------------------------------------------------------- FSM
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        drain_d = '0;
        case (state_q)
            S_IDLE:  if (accept) state_d = last_pix ? S_DRAIN : S_RUN;
            S_RUN:   if (accept && last_pix) state_d = S_DRAIN;
            S_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd2) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------- counters, weights, window
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        wcnt_d = wcnt_q;
        wbuf_d = wbuf_q;
        win_d  = win_q;
        if (accept) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = last_pix ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            // Only the first 9 weighted beats of a frame load the kernel.
            if (weight_valid && (wcnt_q < 4'd9)) begin
                wbuf_d[wcnt_q] = $signed(In_Weight);
                wcnt_d         = wcnt_q + 4'd1;
            end
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb1_q[col_q];
            win_d[1][2] = lb0_q[col_q];
            win_d[2][2] = $signed(In_IFM);
        end
        // Leaving the frame: clear per-frame state. The kernel is cleared too
        // so that taps not loaded by the next frame read as 0.
        if (frame_end) begin
            col_d  = '0;
            row_d  = '0;
            wcnt_d = '0;
            for (int k = 0; k < 9; k++) wbuf_d[k] = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) win_d[i][j] = '0;
        end
    end

    // ------------------------------------------------------- final adder
    always_comb begin
        sum_d = OUT_W'(rsum_q[0]) + OUT_W'(rsum_q[1]) + OUT_W'(rsum_q[2]);
`ifdef CONV_RELU_EN
        ofm_d = sum_d[OUT_W-1] ? '0 : sum_d;
`else
        ofm_d = sum_d;
`endif
    end

    // NOTE: the line buffers have no reset. Every entry is written by rows 0
    // and 1 before any window (row >= 2) reads it, so stale contents never
    // reach an output.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= $signed(In_IFM);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            drain_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            wcnt_q       <= '0;
            for (int k = 0; k < 9; k++) begin
                wbuf_q[k] <= '0;
                prod_q[k] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                rsum_q[i] <= '0;
                for (int j = 0; j < 3; j++) win_q[i][j] <= '0;
            end
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            ofm_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wcnt_q  <= wcnt_d;
            wbuf_q  <= wbuf_d;
            win_q   <= win_d;

            // T+1: products of the just-completed window and current kernel.
            v1_q <= fire;
            for (int k = 0; k < 9; k++)
                prod_q[k] <= PROD_W'(win_d[k/3][k%3]) * PROD_W'(wbuf_d[k]);

            // T+2: row sums, sign-extended so three terms cannot overflow.
            v2_q <= v1_q;
            for (int i = 0; i < 3; i++)
                rsum_q[i] <= RSUM_W'(prod_q[3*i]) + RSUM_W'(prod_q[3*i+1])
                           + RSUM_W'(prod_q[3*i+2]);

            // T+3: registered output, held between valid pulses.
            out_valid_q <= v2_q;
            if (v2_q) ofm_q <= ofm_d;

            frame_done_q <= frame_end;
        end
    end

    assign out_valid  = out_valid_q;
    assign Out_OFM    = ofm_q;
    assign frame_done = frame_done_q;

endmodule
